// File: rtl/qupls4_ins_extract_pkg.sv
// Shared types and constants for the parcel extractor that feeds the instruction decoder.
// A parcel is 48 bits; its opcode lives in the low 7 bits.
package qupls4_ins_extract_pkg;

    typedef logic [31:0] pc_address_t;
    typedef logic [47:0] parcel_t;

    typedef struct packed {
        logic [40:0] payload;
        logic [6:0]  opcode;
    } micro_op_t;

    localparam logic [6:0]  OP_PFX       = 7'h7F;
    localparam int unsigned INS_RAW_BITS = 336;
    localparam int unsigned SCAN_WIN     = 7;

    function automatic logic is_pfx(parcel_t p);
        return p[6:0] == OP_PFX;
    endfunction

endpackage

// File: rtl/qupls4_ins_extract_if.sv
// Fetch-block input and micro-op output handshakes of the extractor.
// The master modport is the extractor side.
interface qupls4_ins_extract_if #(
    parameter int unsigned FBW = 8
);
    import qupls4_ins_extract_pkg::*;

    logic                    fb_v;
    logic                    fb_rdy;
    pc_address_t             fb_ip;
    logic [FBW*48-1:0]       fb_data;
    logic                    ins_v;
    logic                    ins_rdy;
    pc_address_t             ins_ip;
    micro_op_t               ins;
    logic [INS_RAW_BITS-1:0] ins_raw;
    logic [2:0]              ins_len;
    logic                    ins_orphan;

    modport master (
        input  fb_v, fb_ip, fb_data, ins_rdy,
        output fb_rdy, ins_v, ins_ip, ins, ins_raw, ins_len, ins_orphan
    );

    modport slave (
        output fb_v, fb_ip, fb_data, ins_rdy,
        input  fb_rdy, ins_v, ins_ip, ins, ins_raw, ins_len, ins_orphan
    );

endinterface

// File: rtl/qupls4_pfx_scan.sv
// Combinational grouping of the head parcel with its trailing postfix parcels.
// Only the first 'count' window entries hold valid parcels.
module qupls4_pfx_scan
    import qupls4_ins_extract_pkg::*;
#(
    parameter int unsigned MAXPFX = 6,
    parameter int unsigned CW     = 5
) (
    input  parcel_t [SCAN_WIN-1:0]   win,
    input  logic [CW-1:0]            count,
    output logic [2:0]               n,
    output logic [2:0]               len,
    output logic                     complete,
    output logic                     orphan,
    output logic [INS_RAW_BITS-1:0]  raw
);

    logic run;

    always_comb begin
        n        = '0;
        len      = '0;
        complete = 1'b0;
        orphan   = 1'b0;
        raw      = '0;
        run      = 1'b1;
        for (int k = 1; k <= int'(MAXPFX); k++) begin
            if (run && k < int'(count) && is_pfx(win[k])) n = n + 3'd1;
            else run = 1'b0;
        end
        if (count != '0) begin
            orphan = is_pfx(win[0]);
            if (orphan) begin
                n        = '0;
                complete = 1'b1;
            end else begin
                // The terminator must be visible unless the postfix run hit its cap.
                complete = (n == 3'(MAXPFX)) || (int'(n) + 1 < int'(count));
            end
        end
        len = n + 3'd1;
        for (int k = 0; k < int'(SCAN_WIN); k++) begin
            if (k <= int'(n)) raw[48*k +: 48] = win[k];
        end
    end

endmodule

// File: rtl/qupls4_ins_extract.sv
// Buffers sequential fetch blocks of parcels and emits one base+postfix group per cycle
// through a 1-deep output register.
module qupls4_ins_extract
    import qupls4_ins_extract_pkg::*;
#(
    parameter int unsigned FBW    = 8,
    parameter int unsigned BUFP   = 16,
    parameter int unsigned MAXPFX = 6
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  flush,
    qupls4_ins_extract_if.master bus
);

    localparam int unsigned IW = $clog2(BUFP);
    localparam int unsigned CW = $clog2(BUFP) + 1;

    parcel_t                 buf_q [BUFP];
    logic [IW-1:0]           head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]           count_q, count_d;
    pc_address_t             head_ip_q, head_ip_d;
    logic                    ins_v_q, ins_v_d;
    micro_op_t               ins_q, ins_d;
    logic [INS_RAW_BITS-1:0] ins_raw_q, ins_raw_d;
    pc_address_t             ins_ip_q, ins_ip_d;
    logic [2:0]              ins_len_q, ins_len_d;
    logic                    ins_orphan_q, ins_orphan_d;

    parcel_t [SCAN_WIN-1:0]  win;
    logic [2:0]              scan_n, scan_len;
    logic                    scan_complete, scan_orphan;
    logic [INS_RAW_BITS-1:0] scan_raw;
    logic                    accept, load;

    always_comb begin
        win = '0;
        for (int k = 0; k < int'(SCAN_WIN); k++) win[k] = buf_q[head_q + IW'(k)];
    end

    qupls4_pfx_scan #(
        .MAXPFX (MAXPFX),
        .CW     (CW)
    ) u_scan (
        .win      (win),
        .count    (count_q),
        .n        (scan_n),
        .len      (scan_len),
        .complete (scan_complete),
        .orphan   (scan_orphan),
        .raw      (scan_raw)
    );

    assign bus.fb_rdy = (count_q <= CW'(BUFP - FBW));
    assign accept     = bus.fb_v & bus.fb_rdy;
    assign load       = scan_complete & (~ins_v_q | bus.ins_rdy);

    always_comb begin
        count_d      = count_q;
        head_d       = head_q;
        tail_d       = tail_q;
        head_ip_d    = head_ip_q;
        ins_v_d      = ins_v_q;
        ins_d        = ins_q;
        ins_raw_d    = ins_raw_q;
        ins_ip_d     = ins_ip_q;
        ins_len_d    = ins_len_q;
        ins_orphan_d = ins_orphan_q;
        if (flush) begin
            count_d      = '0;
            head_d       = '0;
            tail_d       = '0;
            head_ip_d    = '0;
            ins_v_d      = 1'b0;
            ins_d        = '0;
            ins_raw_d    = '0;
            ins_ip_d     = '0;
            ins_len_d    = '0;
            ins_orphan_d = 1'b0;
        end else begin
            count_d = count_q + (accept ? CW'(FBW) : CW'(0)) - (load ? CW'(scan_len) : CW'(0));
            if (accept) tail_d = tail_q + IW'(FBW);
            // An empty buffer has no meaningful head address, so it is taken from the block.
            if (accept && count_q == '0) head_ip_d = bus.fb_ip;
            else if (load) head_ip_d = head_ip_q + pc_address_t'(6 * int'(scan_len));
            if (load) begin
                head_d       = head_q + IW'(scan_len);
                ins_v_d      = 1'b1;
                ins_d        = win[0];
                ins_raw_d    = scan_raw;
                ins_ip_d     = head_ip_q;
                ins_len_d    = scan_len;
                ins_orphan_d = scan_orphan;
            end else if (bus.ins_rdy) begin
                ins_v_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            head_ip_q    <= '0;
            ins_v_q      <= 1'b0;
            ins_q        <= '0;
            ins_raw_q    <= '0;
            ins_ip_q     <= '0;
            ins_len_q    <= '0;
            ins_orphan_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            head_ip_q    <= head_ip_d;
            ins_v_q      <= ins_v_d;
            ins_q        <= ins_d;
            ins_raw_q    <= ins_raw_d;
            ins_ip_q     <= ins_ip_d;
            ins_len_q    <= ins_len_d;
            ins_orphan_q <= ins_orphan_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < int'(FBW); k++) buf_q[tail_q + IW'(k)] <= bus.fb_data[48*k +: 48];
        end
    end

    assign bus.ins_v      = ins_v_q;
    assign bus.ins        = ins_q;
    assign bus.ins_raw    = ins_raw_q;
    assign bus.ins_ip     = ins_ip_q;
    assign bus.ins_len    = ins_len_q;
    assign bus.ins_orphan = ins_orphan_q;

    assert property (@(posedge clk) disable iff (rst) count_q <= CW'(BUFP));
    assert property (@(posedge clk) disable iff (rst) !load || CW'(scan_len) <= count_q);
    assert property (@(posedge clk) disable iff (rst) ins_len_q <= 3'(1 + MAXPFX));
    assert property (@(posedge clk) disable iff (rst) scan_n <= 3'(MAXPFX));

endmodule

// File: tb/tb_qupls4_ins_extract.sv
// Bench for qupls4_ins_extract: directed block patterns plus random traffic, checked
// every cycle against a queue-based model of the buffer and output register.
module tb_qupls4_ins_extract;
    import qupls4_ins_extract_pkg::*;

    localparam int FBW    = 8;
    localparam int BUFP   = 16;
    localparam int MAXPFX = 6;
    localparam int BW     = FBW * 48;

    typedef struct {
        parcel_t     p;
        pc_address_t ip;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    qupls4_ins_extract_if #(.FBW(FBW)) bus ();

    qupls4_ins_extract #(
        .FBW    (FBW),
        .BUFP   (BUFP),
        .MAXPFX (MAXPFX)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model state: parcels still in the buffer, plus the output register.
    ent_t                    q[$];
    bit                      ov;
    pc_address_t             e_ip, next_ip;
    parcel_t                 e_ins;
    logic [INS_RAW_BITS-1:0] e_raw;
    int                      e_len;
    bit                      e_orph;
    int                      n_checks = 0;
    int                      n_fail   = 0;

    task automatic check_eq(input string tag, input logic [335:0] got, input logic [335:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        ov      = 1'b0;
        e_ip    = '0;
        e_ins   = '0;
        e_raw   = '0;
        e_len   = 0;
        e_orph  = 1'b0;
        next_ip = '0;
    endfunction

    // Group at the front of the queue, derived directly from the grouping rules.
    function automatic void grp(output bit ok, output int len, output bit orph,
                                output logic [INS_RAW_BITS-1:0] raw);
        int n = 0;
        ok   = 1'b0;
        len  = 0;
        orph = 1'b0;
        raw  = '0;
        if (q.size() > 0) begin
            raw[47:0] = q[0].p;
            if (is_pfx(q[0].p)) begin
                ok   = 1'b1;
                len  = 1;
                orph = 1'b1;
            end else begin
                while (n < MAXPFX && n + 1 < q.size() && is_pfx(q[n+1].p)) begin
                    n++;
                    raw[48*n +: 48] = q[n].p;
                end
                ok  = (n == MAXPFX) || (n + 1 < q.size());
                len = n + 1;
            end
        end
    endfunction

    task automatic model_step(input bit fv, input logic [BW-1:0] d, input pc_address_t ip,
                              input bit rdy, input bit fl);
        bit ok, orph, was_empty, acc;
        int len;
        logic [INS_RAW_BITS-1:0] raw;
        if (fl) begin
            model_reset();
        end else begin
            grp(ok, len, orph, raw);
            was_empty = (q.size() == 0);
            acc       = fv && (q.size() <= BUFP - FBW);
            if (ok && (!ov || rdy)) begin
                ov     = 1'b1;
                e_ip   = q[0].ip;
                e_ins  = q[0].p;
                e_raw  = raw;
                e_len  = len;
                e_orph = orph;
                repeat (len) void'(q.pop_front());
            end else if (ov && rdy) begin
                ov = 1'b0;
            end
            if (acc) begin
                if (was_empty) next_ip = ip;
                for (int k = 0; k < FBW; k++) begin
                    q.push_back('{p: d[48*k +: 48], ip: next_ip});
                    next_ip = next_ip + 32'd6;
                end
            end
        end
    endtask

    task automatic compare();
        check_eq("fb_rdy", 336'(bus.fb_rdy), 336'(q.size() <= BUFP - FBW));
        check_eq("ins_v", 336'(bus.ins_v), 336'(ov));
        if (ov) begin
            check_eq("ins_ip", 336'(bus.ins_ip), 336'(e_ip));
            check_eq("ins", 336'(bus.ins), 336'(e_ins));
            check_eq("ins_raw", bus.ins_raw, e_raw);
            check_eq("ins_len", 336'(bus.ins_len), 336'(e_len));
            check_eq("ins_orphan", 336'(bus.ins_orphan), 336'(e_orph));
        end
    endtask

    task automatic drive_step(input bit fv, input logic [BW-1:0] d, input pc_address_t ip,
                              input bit rdy, input bit fl);
        bus.fb_v    = fv;
        bus.fb_data = d;
        bus.fb_ip   = ip;
        bus.ins_rdy = rdy;
        flush       = fl;
        model_step(fv, d, ip, rdy, fl);
    endtask

    task automatic cycle(input bit fv, input logic [BW-1:0] d, input pc_address_t ip,
                         input bit rdy, input bit fl);
        @(negedge clk);
        compare();
        drive_step(fv, d, ip, rdy, fl);
    endtask

    // mask bit k set makes parcel k a postfix; other parcels get a non-postfix opcode.
    function automatic logic [BW-1:0] mk_block(input logic [FBW-1:0] mask);
        logic [BW-1:0] b;
        parcel_t p;
        for (int k = 0; k < FBW; k++) begin
            p = parcel_t'({$urandom(), $urandom()});
            if (mask[k]) p[6:0] = OP_PFX;
            else if (p[6:0] == OP_PFX) p[6:0] = 7'h01;
            b[48*k +: 48] = p;
        end
        return b;
    endfunction

    function automatic logic [FBW-1:0] rand_mask();
        logic [FBW-1:0] m;
        for (int k = 0; k < FBW; k++) m[k] = ($urandom_range(0, 9) < 3);
        return m;
    endfunction

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        bus.fb_v    = 1'b0;
        bus.fb_data = '0;
        bus.fb_ip   = '0;
        bus.ins_rdy = 1'b0;
        model_reset();
        #1;
        check_eq("rst_ins_v", 336'(bus.ins_v), 336'(0));
        check_eq("rst_fb_rdy", 336'(bus.fb_rdy), 336'(1));
        check_eq("rst_ins", 336'(bus.ins), 336'(0));
        check_eq("rst_ins_raw", bus.ins_raw, 336'(0));
        check_eq("rst_ins_ip", 336'(bus.ins_ip), 336'(0));
        check_eq("rst_ins_len", 336'(bus.ins_len), 336'(0));
        check_eq("rst_ins_orphan", 336'(bus.ins_orphan), 336'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // One block of plain instructions.
        cycle(1'b1, mk_block(8'h00), 32'h1000, 1'b1, 1'b0);
        repeat (10) cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // base, PFX, PFX, base, then plain parcels.
        cycle(1'b0, '0, '0, 1'b1, 1'b1);
        cycle(1'b1, mk_block(8'h06), 32'h1000, 1'b1, 1'b0);
        repeat (10) cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Group split across two blocks and the buffer wrap point.
        cycle(1'b1, mk_block(8'hC0), 32'h1030, 1'b1, 1'b0);
        repeat (8) cycle(1'b0, '0, '0, 1'b1, 1'b0);
        cycle(1'b1, mk_block(8'h01), 32'h1060, 1'b1, 1'b0);
        repeat (10) cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Decoder stalled while fetch keeps pushing.
        for (int i = 0; i < 20; i++) cycle(1'b1, mk_block(rand_mask()), $urandom(), 1'b0, 1'b0);
        repeat (40) cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Orphan postfix at the head, then a base followed by seven postfixes.
        cycle(1'b0, '0, '0, 1'b1, 1'b1);
        cycle(1'b1, mk_block(8'h01), 32'h2000, 1'b1, 1'b0);
        repeat (10) cycle(1'b0, '0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b1);
        cycle(1'b1, mk_block(8'hFE), 32'h2100, 1'b1, 1'b0);
        repeat (6) cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Asynchronous reset with a valid micro-op held and parcels buffered.
        cycle(1'b1, mk_block(8'h00), 32'h3000, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
        cycle(1'b1, mk_block(8'h10), 32'h3030, 1'b0, 1'b0);
        @(negedge clk);
        compare();
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_ins_v", 336'(bus.ins_v), 336'(0));
        check_eq("async_rst_fb_rdy", 336'(bus.fb_rdy), 336'(1));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive_step(1'b0, '0, '0, 1'b1, 1'b0);

        // A flush drops the block offered with it; the next block sets the head address.
        cycle(1'b1, mk_block(8'h00), 32'h4000, 1'b1, 1'b0);
        cycle(1'b1, mk_block(8'h00), 32'h4030, 1'b1, 1'b1);
        cycle(1'b1, mk_block(8'h00), 32'h5000, 1'b1, 1'b0);
        repeat (10) cycle(1'b0, '0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), mk_block(rand_mask()), $urandom(),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
        end
        repeat (30) cycle(1'b0, '0, '0, 1'b1, 1'b0);
        @(negedge clk);
        compare();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
